// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Package     : systolic_pkg
// Description : Shared FSM state encoding and default geometry for the
//               systolic skew feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int SYS_WIDTH = 8;
    localparam int SYS_DIM   = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/skew_lane.sv
`default_nettype none
// ============================================================================
// Module      : skew_lane
// Description : DEPTH-stage register delay line, synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_lane #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_data;
            for (int s = 1; s < DEPTH; s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_skew_feeder
// Description : Accepts DIM operand beats and feeds them to a DIMxDIM systolic
//               array with lane i delayed by i+1 cycles, then waits for the
//               array to drain. Define SKEW_FEEDER_PERF_EN to add stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int WIDTH = SYS_WIDTH,
    parameter int DIM   = SYS_DIM
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DIM-1:0][WIDTH-1:0]   in_left,
    input  logic [DIM-1:0][WIDTH-1:0]   in_top,
    output logic [DIM-1:0][WIDTH-1:0]   out_left,
    output logic [DIM-1:0][WIDTH-1:0]   out_top,
    output logic                        busy,
    output logic                        done
`ifdef SKEW_FEEDER_PERF_EN
    ,
    output logic [15:0]                 stall_cnt
`endif
);

    localparam logic [1:0] c_IDLE  = ST_IDLE;
    localparam logic [1:0] c_LOAD  = ST_LOAD;
    localparam logic [1:0] c_DRAIN = ST_DRAIN;
    localparam logic [1:0] c_DONE  = ST_DONE;

    localparam int CW = $clog2(DIM + 1);
    localparam int DW = $clog2(2 * DIM + 1);
    localparam logic [CW-1:0] c_LAST_BEAT  = CW'(DIM - 1);
    localparam logic [DW-1:0] c_LAST_DRAIN = DW'(2 * DIM - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_beat;
    logic [DW-1:0] r_drain;
    logic          w_accept;

    logic [DIM-1:0][WIDTH-1:0] w_feed_left;
    logic [DIM-1:0][WIDTH-1:0] w_feed_top;

    assign in_ready = (r_state == c_IDLE) || (r_state == c_LOAD);
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state == c_LOAD) || (r_state == c_DRAIN);
    assign done     = (r_state == c_DONE);

    // Cycles without an accepted beat push zeros so the skew stays aligned.
    assign w_feed_left = w_accept ? in_left : '0;
    assign w_feed_top  = w_accept ? in_top  : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_beat  <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_LOAD;
                        r_beat  <= CW'(1);
                    end
                end
                c_LOAD: begin
                    if (w_accept) begin
                        r_beat <= r_beat + CW'(1);
                        if (r_beat == c_LAST_BEAT) begin
                            r_state <= c_DRAIN;
                            r_drain <= '0;
                        end
                    end
                end
                c_DRAIN: begin
                    if (r_drain == c_LAST_DRAIN) begin
                        r_state <= c_DONE;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        skew_lane #(
            .WIDTH (WIDTH),
            .DEPTH (gi + 1)
        ) u_left (
            .clk    (clock),
            .rst_n  (reset),
            .i_data (w_feed_left[gi]),
            .o_data (out_left[gi])
        );

        skew_lane #(
            .WIDTH (WIDTH),
            .DEPTH (gi + 1)
        ) u_top (
            .clk    (clock),
            .rst_n  (reset),
            .i_data (w_feed_top[gi]),
            .o_data (out_top[gi])
        );
    end

`ifdef SKEW_FEEDER_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if ((r_state == c_IDLE) && w_accept) begin
            r_stall_cnt <= '0;
        end else if ((r_state == c_LOAD) && !w_accept && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
